// File: rtl/anubis_seq.sv
// -----------------------------------------------------------------------------
// anubis_seq
//
// Command sequencer placed directly in front of the Anubis_2 cipher core.
// It takes a 128-bit key and a stream of 128-bit data blocks over valid/ready
// handshakes. For each block it drives the core's data_in/order/reset pins
// through the load/run sequence the core needs, then captures the core's
// data_out into a result register with a one-cycle valid strobe.
//
// The core keeps its key schedule between blocks, so the key-load phase (and
// the core reset that starts it) runs only when a new key has arrived since
// the last load.
//
// Ports
//   clk         in   1    single clock, rising edge
//   reset       in   1    synchronous, active-low reset
//   key_in      in   128  key value
//   key_valid   in   1    key strobe, always accepted
//   blk_in      in   128  input data block
//   blk_valid   in   1    block offered
//   blk_ready   out  1    block accepted when blk_valid && blk_ready
//   core_data   out  128  to core data_in
//   core_order  out  2    to core order
//   core_rst    out  1    to core reset (active high on the core side)
//   core_dout   in   128  from core data_out
//   res_data    out  128  captured result, held until the next capture
//   res_valid   out  1    one-cycle pulse in the cycle res_data updates
// -----------------------------------------------------------------------------
module anubis_seq #(
    parameter int KEY_CYCLES = 4,   // key-load cycles incl. the core-reset cycle, 2..31
    parameter int RUN_CYCLES = 15   // cycles with order=10 per block, 1..31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    input  logic [127:0] blk_in,
    input  logic         blk_valid,
    output logic         blk_ready,
    output logic [127:0] core_data,
    output logic [1:0]   core_order,
    output logic         core_rst,
    input  logic [127:0] core_dout,
    output logic [127:0] res_data,
    output logic         res_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KEYLD = 2'd1,
        ST_DATLD = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam logic [4:0] KEY_LAST = 5'(KEY_CYCLES - 1);
    localparam logic [4:0] RUN_LAST = 5'(RUN_CYCLES - 1);

    localparam logic [1:0] ORD_LOAD_KEY = 2'b00;
    localparam logic [1:0] ORD_LOAD_DAT = 2'b01;
    localparam logic [1:0] ORD_RUN      = 2'b10;

    // State registers
    state_t       state_r;
    logic [4:0]   cnt_r;
    logic [127:0] key_r;
    logic         have_key_r;
    logic         key_dirty_r;
    logic [127:0] blk_r;
    logic [127:0] res_data_r;
    logic         res_valid_r;
    logic         blk_ready_r;
    logic [127:0] core_data_r;
    logic [1:0]   core_order_r;
    logic         core_rst_r;

    // Next-state values
    state_t       state_s;
    logic [4:0]   cnt_s;
    logic [127:0] key_s;
    logic         have_key_s;
    logic         key_dirty_s;
    logic [127:0] blk_s;
    logic [127:0] res_data_s;
    logic         res_valid_s;
    logic         blk_ready_s;
    logic [127:0] core_data_s;
    logic [1:0]   core_order_s;
    logic         core_rst_s;
    logic         accept_s;

    // blk_ready_r already equals (state_r == IDLE) && have_key_r, so the
    // accept decision has no combinational path back to blk_valid's producer.
    assign accept_s = blk_valid && blk_ready_r;

    // Next-state logic: sequencing FSM, key intake and result capture
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        key_s       = key_r;
        have_key_s  = have_key_r;
        key_dirty_s = key_dirty_r;
        blk_s       = blk_r;
        res_data_s  = res_data_r;
        res_valid_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    blk_s = blk_in;
                    cnt_s = 5'd0;
                    // A key arriving on the accept edge counts as dirty, so
                    // this block is encrypted under the new key.
                    if (key_dirty_r || key_valid) begin
                        state_s = ST_KEYLD;
                    end else begin
                        state_s = ST_DATLD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_KEYLD: begin
                if (cnt_r == KEY_LAST) begin
                    state_s     = ST_DATLD;
                    cnt_s       = 5'd0;
                    key_dirty_s = 1'b0;  // a key_valid below on this edge overrides
                end else begin
                    cnt_s = cnt_r + 5'd1;
                end
            end

            ST_DATLD: begin
                state_s = ST_RUN;
                cnt_s   = 5'd0;
            end

            ST_RUN: begin
                if (cnt_r == RUN_LAST) begin
                    state_s     = ST_IDLE;
                    cnt_s       = 5'd0;
                    res_data_s  = core_dout;
                    res_valid_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + 5'd1;
                end
            end

            default: begin
                state_s = ST_IDLE;
                cnt_s   = 5'd0;
            end
        endcase

        // Key intake is independent of state; a key changed while busy only
        // reaches the core at the next key-load phase.
        if (key_valid) begin
            key_s       = key_in;
            key_dirty_s = 1'b1;
            have_key_s  = 1'b1;
        end else begin
            key_s = key_r;
        end
    end

    // Core pin and ready decode from the next state, so the registered pins
    // line up with the state they belong to
    always_comb begin
        core_data_s  = blk_s;
        core_order_s = ORD_LOAD_KEY;
        core_rst_s   = 1'b0;

        case (state_s)
            ST_IDLE: begin
                core_data_s  = blk_s;
                core_order_s = ORD_LOAD_KEY;
            end
            ST_KEYLD: begin
                core_data_s  = key_s;
                core_order_s = ORD_LOAD_KEY;
                core_rst_s   = (cnt_s == 5'd0);
            end
            ST_DATLD: begin
                core_data_s  = blk_s;
                core_order_s = ORD_LOAD_DAT;
            end
            ST_RUN: begin
                core_data_s  = blk_s;
                core_order_s = ORD_RUN;
            end
            default: begin
                core_data_s  = blk_s;
                core_order_s = ORD_LOAD_KEY;
            end
        endcase

        blk_ready_s = (state_s == ST_IDLE) && have_key_s;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 5'd0;
            key_r        <= 128'd0;
            have_key_r   <= 1'b0;
            key_dirty_r  <= 1'b0;
            blk_r        <= 128'd0;
            res_data_r   <= 128'd0;
            res_valid_r  <= 1'b0;
            blk_ready_r  <= 1'b0;
            core_data_r  <= 128'd0;
            core_order_r <= 2'b00;
            core_rst_r   <= 1'b1;   // hold the core in reset while we are
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            key_r        <= key_s;
            have_key_r   <= have_key_s;
            key_dirty_r  <= key_dirty_s;
            blk_r        <= blk_s;
            res_data_r   <= res_data_s;
            res_valid_r  <= res_valid_s;
            blk_ready_r  <= blk_ready_s;
            core_data_r  <= core_data_s;
            core_order_r <= core_order_s;
            core_rst_r   <= core_rst_s;
        end
    end

    assign blk_ready  = blk_ready_r;
    assign core_data  = core_data_r;
    assign core_order = core_order_r;
    assign core_rst   = core_rst_r;
    assign res_data   = res_data_r;
    assign res_valid  = res_valid_r;

endmodule

// File: tb/tb_anubis_seq.sv
// -----------------------------------------------------------------------------
// Testbench for anubis_seq. A small stand-in core model answers the core pins:
// it latches the key during the load phase, latches the block on order=01 and
// counts order=10 cycles, producing data_out = key ^ swap64(block) ^ run_count.
// Expected results are pushed into a queue at each accept and popped when
// res_valid pulses.
// -----------------------------------------------------------------------------
module tb_anubis_seq;

    localparam int KC = 4;
    localparam int RC = 15;

    localparam logic [127:0] K1 = 128'h138b408b6E3C231cEDC05b8132dE786e;
    localparam logic [127:0] K2 = 128'h09d26d8129ACFf12CD036A45FC2ddc31;
    localparam logic [127:0] K3 = 128'h5A5A_0F0F_1234_5678_9ABC_DEF0_C3C3_A5A5;
    localparam logic [127:0] K4 = 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
    localparam logic [127:0] B1 = 128'h8B9cF140834BB85C483AB8FAabefF33C;
    localparam logic [127:0] B2 = 128'hB7AB13ef9bb0F4Cc61A6caAcfBC00cDA;
    localparam logic [127:0] B3 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    localparam logic [127:0] B4 = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
    localparam logic [127:0] B5 = 128'h1357_9BDF_2468_ACE0_0F1E_2D3C_4B5A_6978;
    localparam logic [127:0] B6 = 128'hAAAA_5555_FFFF_0000_1234_4321_ABCD_DCBA;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key_in;
    logic         key_valid;
    logic [127:0] blk_in;
    logic         blk_valid;
    logic         blk_ready;
    logic [127:0] core_data;
    logic [1:0]   core_order;
    logic         core_rst;
    logic [127:0] core_dout;
    logic [127:0] res_data;
    logic         res_valid;

    always #5 clk = ~clk;

    anubis_seq #(.KEY_CYCLES(KC), .RUN_CYCLES(RC)) dut (
        .clk(clk), .reset(reset),
        .key_in(key_in), .key_valid(key_valid),
        .blk_in(blk_in), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .core_data(core_data), .core_order(core_order), .core_rst(core_rst),
        .core_dout(core_dout),
        .res_data(res_data), .res_valid(res_valid)
    );

    // Stand-in core
    logic         fc_loading = 1'b0;
    logic [127:0] fc_ks      = 128'd0;
    logic [127:0] fc_din     = 128'd0;
    logic [4:0]   fc_rc      = 5'd0;

    always @(posedge clk) begin
        if (core_rst) fc_loading <= 1'b1;
        else if (core_order == 2'b01) fc_loading <= 1'b0;
        if ((core_rst || fc_loading) && core_order == 2'b00) fc_ks <= core_data;
        if (core_order == 2'b01) begin
            fc_din <= core_data;
            fc_rc  <= 5'd0;
        end else if (core_order == 2'b10) begin
            fc_rc <= fc_rc + 5'd1;
        end
    end
    assign core_dout = fc_ks ^ {fc_din[63:0], fc_din[127:64]} ^ {123'd0, fc_rc};

    // Result the stand-in core yields after RC run cycles
    function automatic logic [127:0] exp_res(input logic [127:0] k, input logic [127:0] b);
        return k ^ {b[63:0], b[127:64]} ^ 128'(RC - 1);
    endfunction

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    logic [127:0] exp_q[$];
    logic [127:0] m_key      = 128'd0;
    logic [127:0] m_core_key = 128'd0;
    logic         m_dirty    = 1'b0;

    logic         obs_rst, obs_rv, obs_ready, obs_acc;
    logic [1:0]   obs_order;
    logic [127:0] obs_data, obs_res;

    // One cycle: sample on the falling edge, update the reference model and
    // scoreboard, then return just after the next rising edge for driving.
    task automatic step();
        logic [127:0] e;
        @(negedge clk);
        step_no++;
        obs_rst   = core_rst;
        obs_order = core_order;
        obs_data  = core_data;
        obs_ready = blk_ready;
        obs_rv    = res_valid;
        obs_res   = res_data;
        obs_acc   = reset && blk_valid && blk_ready;
        if (res_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_result res_data=%h with no block pending", res_data);
            end else begin
                e = exp_q.pop_front();
                if (res_data !== e) begin
                    failures++;
                    $display("FAIL sb_res_data got=%h exp=%h", res_data, e);
                end
            end
        end
        if (!reset) begin
            m_dirty = 1'b0;
            exp_q.delete();
        end else begin
            if (key_valid) begin
                m_key   = key_in;
                m_dirty = 1'b1;
            end
            if (obs_acc) begin
                if (m_dirty) begin
                    m_core_key = m_key;
                    m_dirty    = 1'b0;
                end
                exp_q.push_back(exp_res(m_core_key, blk_in));
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_key(input logic [127:0] k);
        key_in = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic offer_block(input logic [127:0] b, output int acc_step);
        blk_in = b;
        blk_valid = 1'b1;
        acc_step = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs_acc) begin
                acc_step = step_no;
                break;
            end
        end
        blk_valid = 1'b0;
    endtask

    // Steps until res_valid (bounded); optionally pulses a key so that it is
    // registered on edge kj counted from the accept edge.
    task automatic wait_result(input int kj, input logic [127:0] kv,
                               output int lat, output bit saw_rst);
        lat = -1;
        saw_rst = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            key_valid = (j == kj);
            key_in = kv;
            step();
            if (obs_rst) saw_rst = 1'b1;
            if (obs_rv) begin
                lat = j - 1;
                break;
            end
        end
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        blk_valid = 1'b1;
        blk_in = B1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({obs_rst, obs_order, obs_data, obs_rv, obs_res, obs_ready} !==
                {1'b1, 2'b00, 128'd0, 1'b0, 128'd0, 1'b0}) begin
                failures++;
                $display("FAIL reset_values rst=%b ord=%b data=%h rv=%b res=%h rdy=%b",
                         obs_rst, obs_order, obs_data, obs_rv, obs_res, obs_ready);
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if (obs_ready !== 1'b0 || (i >= 2 && obs_rst !== 1'b0)) begin
                failures++;
                $display("FAIL no_key_ready cycle=%0d rdy=%b rst=%b exp rdy=0 rst=0", i, obs_ready, obs_rst);
            end
        end
        blk_valid = 1'b0;
    endtask

    task automatic test_key_block();
        int acc;
        int lat;
        logic         er;
        logic [1:0]   eo;
        logic [127:0] ed;
        pulse_key(K1);
        offer_block(B1, acc);
        checks++;
        if (acc < 0) begin
            failures++;
            $display("FAIL key_block_accept got=none exp=accept");
        end
        lat = -1;
        for (int j = 1; j <= 24; j++) begin
            step();
            er = 1'b0;
            eo = 2'b00;
            ed = B1;
            if (j <= KC) begin
                er = (j == 1);
                ed = K1;
            end else if (j == KC + 1) begin
                eo = 2'b01;
            end else if (j <= KC + 1 + RC) begin
                eo = 2'b10;
            end
            checks++;
            if ({obs_rst, obs_order, obs_data} !== {er, eo, ed}) begin
                failures++;
                $display("FAIL core_pins cycle=%0d got rst=%b ord=%b data=%h exp rst=%b ord=%b data=%h",
                         j, obs_rst, obs_order, obs_data, er, eo, ed);
            end
            if (obs_rv && lat < 0) begin
                lat = j - 1;
                checks++;
                if (obs_res !== exp_res(K1, B1)) begin
                    failures++;
                    $display("FAIL key_block_result got=%h exp=%h", obs_res, exp_res(K1, B1));
                end
            end
        end
        checks++;
        if (lat != KC + 1 + RC) begin
            failures++;
            $display("FAIL dirty_latency got=%0d exp=%0d", lat, KC + 1 + RC);
        end
    endtask

    task automatic test_clean_key();
        int acc;
        int lat;
        bit sr;
        offer_block(B2, acc);
        wait_result(0, 128'd0, lat, sr);
        checks++;
        if (acc < 0 || lat != 1 + RC || sr) begin
            failures++;
            $display("FAIL clean_latency acc=%0d got lat=%0d rst=%b exp lat=%0d rst=0", acc, lat, sr, 1 + RC);
        end
    endtask

    task automatic test_key_midrun();
        int acc;
        int lat;
        bit sr;
        // Key changes mid-RUN: in-flight block keeps K1
        offer_block(B3, acc);
        wait_result(8, K2, lat, sr);
        checks++;
        if (acc < 0 || lat != 1 + RC || sr) begin
            failures++;
            $display("FAIL midrun_inflight acc=%0d got lat=%0d rst=%b exp lat=%0d rst=0", acc, lat, sr, 1 + RC);
        end
        // Next block reloads K2; K3 arrives on the final key-load edge
        offer_block(B4, acc);
        wait_result(KC, K3, lat, sr);
        checks++;
        if (acc < 0 || lat != KC + 1 + RC || !sr) begin
            failures++;
            $display("FAIL newkey_reload acc=%0d got lat=%0d rst=%b exp lat=%0d rst=1", acc, lat, sr, KC + 1 + RC);
        end
        // Key stayed dirty, so this block reloads again with K3
        offer_block(B5, acc);
        wait_result(0, 128'd0, lat, sr);
        checks++;
        if (acc < 0 || lat != KC + 1 + RC || !sr) begin
            failures++;
            $display("FAIL last_edge_key_dirty acc=%0d got lat=%0d rst=%b exp lat=%0d rst=1", acc, lat, sr, KC + 1 + RC);
        end
    endtask

    task automatic test_reset_midrun();
        int acc;
        offer_block(B6, acc);
        for (int i = 0; i < 8; i++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        checks++;
        if ({obs_rst, obs_order, obs_data, obs_rv, obs_res, obs_ready} !==
            {1'b1, 2'b00, 128'd0, 1'b0, 128'd0, 1'b0}) begin
            failures++;
            $display("FAIL midrun_reset_values rst=%b ord=%b data=%h rv=%b res=%h rdy=%b",
                     obs_rst, obs_order, obs_data, obs_rv, obs_res, obs_ready);
        end
        blk_valid = 1'b1;
        blk_in = B1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (obs_ready !== 1'b0 || obs_rv !== 1'b0) begin
                failures++;
                $display("FAIL after_reset_idle cycle=%0d rdy=%b rv=%b exp 0 0", i, obs_ready, obs_rv);
            end
        end
        blk_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] blks[4];
        int acc[4];
        int n;
        int nrv;
        blks[0] = B1; blks[1] = B2; blks[2] = B3; blks[3] = B4;
        pulse_key(K4);
        n = 0;
        nrv = 0;
        blk_in = blks[0];
        blk_valid = 1'b1;
        for (int i = 0; i < 150; i++) begin
            step();
            if (obs_rv) nrv++;
            if (obs_acc && n < 4) begin
                acc[n] = step_no;
                n++;
                if (n < 4) blk_in = blks[n];
                else blk_valid = 1'b0;
            end
            if (n == 4 && nrv == 4) break;
        end
        blk_valid = 1'b0;
        checks++;
        if (n != 4 || nrv != 4) begin
            failures++;
            $display("FAIL b2b_counts accepts=%0d results=%0d exp 4 4", n, nrv);
        end else begin
            checks++;
            if (acc[1] - acc[0] != KC + 2 + RC) begin
                failures++;
                $display("FAIL b2b_first_gap got=%0d exp=%0d", acc[1] - acc[0], KC + 2 + RC);
            end
            for (int k = 2; k < 4; k++) begin
                checks++;
                if (acc[k] - acc[k-1] != 2 + RC) begin
                    failures++;
                    $display("FAIL b2b_gap idx=%0d got=%0d exp=%0d", k, acc[k] - acc[k-1], 2 + RC);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        key_in = 128'd0;
        key_valid = 1'b0;
        blk_in = 128'd0;
        blk_valid = 1'b0;
        test_reset();
        test_key_block();
        test_clean_key();
        test_key_midrun();
        test_reset_midrun();
        test_back_to_back();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
